// File: rtl/uart_tx_fifo.sv
// Buffered 8-bit UART transmitter: DEPTH-entry FIFO feeding an LSB-first 8N1 serializer.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit (8E1).
module uart_tx_fifo #(
   parameter int unsigned CLK_HZ = 50_000_000,
   parameter int unsigned BAUD   = 115200,
   parameter int unsigned DEPTH  = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr,
   input  logic [7:0]                 wdata,
   input  logic                       clr_ovrflw,
   output logic                       tbr_valid,
   output logic                       overflow,
   output logic                       busy,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       txd
);

   localparam int unsigned DIV = CLK_HZ / BAUD;
   localparam int unsigned AW  = $clog2(DEPTH);
   localparam int unsigned CW  = $clog2(DIV);

   localparam logic [CW-1:0] BAUD_RELOAD = CW'(DIV - 1);
   localparam logic [AW:0]   FULL_COUNT  = (AW + 1)'(DEPTH);

   if (DIV < 2) begin : g_bad_div
      $error("uart_tx_fifo: CLK_HZ / BAUD must be at least 2");
   end
   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("uart_tx_fifo: DEPTH must be a power of two, at least 2");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
`ifdef UART_TX_PARITY_EN
      ,
      S_PARITY
`endif
   } state_t;

   // FIFO storage and bookkeeping
   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          full;
   logic          push;
   logic          pop;

   // Serializer
   state_t        state_q, state_d;
   logic [CW-1:0] baud_q, baud_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          txd_q, txd_d;
   logic          bit_done;
   logic          start_frame;
`ifdef UART_TX_PARITY_EN
   logic          parity_q, parity_d;
`endif

   // Acceptance looks only at the pre-edge count, so a same-cycle pop never makes room.
   assign full = (count_q == FULL_COUNT);
   assign push = wr && !full;

   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (wr && full) begin
         ovf_d = 1'b1;
      end else if (clr_ovrflw) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // NOTE: the data array has no reset; stale entries are unreachable because count gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bit_done = (baud_q == '0);

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      baud_d      = baud_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      txd_d       = txd_q;
      start_frame = 1'b0;
      pop         = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d    = parity_q;
`endif

      if (state_q != S_IDLE) begin
         baud_d = bit_done ? BAUD_RELOAD : baud_q - 1'b1;
      end

      unique case (state_q)
         S_IDLE: begin
            txd_d = 1'b1;
            if (count_q != '0) begin
               start_frame = 1'b1;
            end
         end
         S_START: begin
            if (bit_done) begin
               state_d   = S_DATA;
               bit_idx_d = 3'd0;
               txd_d     = shift_q[0];
            end
         end
         S_DATA: begin
            if (bit_done) begin
               if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
                  txd_d   = parity_q;
`else
                  state_d = S_STOP;
                  txd_d   = 1'b1;
`endif
               end else begin
                  shift_d   = shift_q >> 1;
                  bit_idx_d = bit_idx_q + 3'd1;
                  txd_d     = shift_q[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_done) begin
               state_d = S_STOP;
               txd_d   = 1'b1;
            end
         end
`endif
         S_STOP: begin
            if (bit_done) begin
               if (count_q != '0) begin
                  start_frame = 1'b1;
               end else begin
                  state_d = S_IDLE;
                  txd_d   = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
         end
      endcase

      // Loading a frame is shared by IDLE and the back-to-back exit of STOP.
      if (start_frame) begin
         pop     = 1'b1;
         shift_d = mem_q[rd_ptr_q];
         baud_d  = BAUD_RELOAD;
         state_d = S_START;
         txd_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_d = ^mem_q[rd_ptr_q];
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         baud_q    <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         txd_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         txd_q     <= txd_d;
`ifdef UART_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   assign tbr_valid = !full;
   assign overflow  = ovf_q;
   assign busy      = (state_q != S_IDLE);
   assign count     = count_q;
   assign txd       = txd_q;

endmodule
